lcd_cmd_feeder: RTL and testbench

- Upstream driver for LCD_CTRL.
- Walks a command ROM and an image ROM, then presents cmd/cmd_valid/datain to LCD_CTRL, honouring its busy handshake.
- On load (cmd 0) it streams exactly IMAGE_N pixels on consecutive cycles.
- It is the synthesizable replacement for bench-side stimulus, so LCD_CTRL can run standalone from on-chip ROM.

---
 rtl/lcd_ctrl_pkg.sv | 33 +++
 rtl/lcd_cmd_feeder.sv | 125 ++++++++++++
 tb/tb_lcd_cmd_feeder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for LCD_CTRL and its command feeder: command codes,
// default geometry and the feeder FSM state encoding.
package lcd_ctrl_pkg;

  localparam int IMAGE_N_DEF = 108;
  localparam int CMD_N_DEF   = 22;
  localparam int DW_DEF      = 8;
  localparam int CW_DEF      = 3;

  localparam logic [2:0] CMD_LOAD     = 3'd0;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
  localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
  localparam logic [2:0] CMD_SHIFT_R  = 3'd3;
  localparam logic [2:0] CMD_SHIFT_L  = 3'd4;
  localparam logic [2:0] CMD_SHIFT_U  = 3'd5;
  localparam logic [2:0] CMD_SHIFT_D  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_LOAD,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Address width that never collapses to zero bits for single-entry ROMs.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_cmd_feeder.sv
// Walks a command ROM (and the image ROM for load commands) and feeds
// LCD_CTRL through its cmd/cmd_valid/busy handshake, one run per start pulse.
module lcd_cmd_feeder
  import lcd_ctrl_pkg::*;
#(
  parameter int  IMAGE_N = IMAGE_N_DEF,
  parameter int  CMD_N   = CMD_N_DEF,
  parameter int  DW      = DW_DEF,
  parameter int  CW      = CW_DEF,
  localparam int CAW     = addr_w(CMD_N),
  localparam int IAW     = addr_w(IMAGE_N),
  localparam int CNW     = addr_w(CMD_N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [CAW-1:0] cmd_rom_addr,
  input  logic [CW-1:0]  cmd_rom_data,
  output logic [IAW-1:0] img_rom_addr,
  input  logic [DW-1:0]  img_rom_data,
  output logic [CW-1:0]  cmd,
  output logic           cmd_valid,
  output logic [DW-1:0]  datain,
  input  logic           busy,
  output logic           running,
  output logic           done,
  output logic [CNW-1:0] cmd_count
);

  state_t         state;
  logic [CNW-1:0] idx;
  logic [IAW-1:0] pix;
  logic [CW-1:0]  cmd_q;
  logic           wait_first;

  logic [CNW-1:0] idx_inc;
  logic           pix_last;
  logic [CW-1:0]  cmd_cur;

  assign idx_inc  = idx + CNW'(1);
  assign pix_last = (pix == IAW'(IMAGE_N - 1));
  // ROM data is only valid on the first WAIT cycle; later cycles use the latch.
  assign cmd_cur  = wait_first ? cmd_rom_data : cmd_q;

  // idx is stable from HOLD through WAIT, so the command ROM address is idx.
  assign cmd_rom_addr = idx[CAW-1:0];

  // Image address runs one ahead of the displayed pixel so the registered
  // ROM delivers each pixel exactly in its LOAD beat.
  always_comb begin
    img_rom_addr = '0;
    datain       = '0;
    if (state == ST_LOAD) begin
      img_rom_addr = pix_last ? pix : pix + IAW'(1);
      datain       = img_rom_data;
    end
  end

  // Run sequencer: fetch, wait for LCD_CTRL idle, issue, optional pixel burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pix        <= '0;
      cmd_q      <= '0;
      wait_first <= 1'b0;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      cmd_count  <= '0;
    end else begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            idx       <= '0;
            running   <= 1'b1;
            cmd_count <= '0;
          end
        end
        ST_FETCH: begin
          state      <= ST_WAIT;
          wait_first <= 1'b1;
        end
        ST_WAIT: begin
          wait_first <= 1'b0;
          if (wait_first) cmd_q <= cmd_rom_data;
          if (!busy) begin
            state     <= ST_ISSUE;
            cmd       <= cmd_cur;
            cmd_valid <= 1'b1;
            cmd_count <= cmd_count + CNW'(1);
          end
        end
        ST_ISSUE: begin
          pix   <= '0;
          state <= (cmd == CW'(CMD_LOAD)) ? ST_LOAD : ST_HOLD;
        end
        ST_LOAD: begin
          // busy is deliberately ignored: LCD_CTRL accepts the burst blindly.
          if (pix_last) state <= ST_HOLD;
          else          pix   <= pix + IAW'(1);
        end
        ST_HOLD: begin
          // One spare cycle lets LCD_CTRL raise busy before the next fetch.
          idx   <= idx_inc;
          state <= (idx_inc == CNW'(CMD_N)) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          if (!busy) begin
            done    <= 1'b1;
            running <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Scoreboard bench for lcd_cmd_feeder: stimulus queues the expected command,
// pixel and done events; a negedge monitor pops and compares them.
module tb_lcd_cmd_feeder;

  localparam int IMAGE_N = 108;
  localparam int CMD_N   = 22;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] cmd_rom_addr;
  logic [2:0] cmd_rom_data;
  logic [6:0] img_rom_addr;
  logic [7:0] img_rom_data;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic       running;
  logic       done;
  logic [4:0] cmd_count;

  lcd_cmd_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_rom_addr(cmd_rom_addr), .cmd_rom_data(cmd_rom_data),
    .img_rom_addr(img_rom_addr), .img_rom_data(img_rom_data),
    .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .busy(busy),
    .running(running), .done(done), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Command ROM contents, including a code LCD_CTRL does not decode (7).
  int rom [CMD_N] = '{0, 1, 3, 4, 5, 6, 2, 0, 3, 3, 4, 5, 1, 6, 7, 2, 0, 5, 6, 4, 1, 3};
  logic [2:0] cmd_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) cmd_mem[i] = (i < CMD_N) ? 3'(rom[i]) : 3'd0;
  end

  // Registered ROM models.
  always @(posedge clk) begin
    cmd_rom_data <= cmd_mem[cmd_rom_addr];
    img_rom_data <= 8'(img_rom_addr) + 8'h10;
  end

  // LCD_CTRL busy model: busy for 20 cycles after each accepted command (mode 1).
  int   busy_mode = 0;
  logic busy_force = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (busy_mode == 1 && cmd_valid) busy_cnt <= 20;
    else if (busy_cnt > 0)           busy_cnt <= busy_cnt - 1;
  end
  assign busy = busy_force | (busy_cnt != 0);

  logic busy_edge = 1'b0;
  int   cyc = 0;
  always @(posedge clk) begin
    busy_edge <= busy;
    cyc       <= cyc + 1;
  end

  typedef struct { int kind; int val; } exp_t;  // kind: 0 cmd, 1 pixel, 2 done
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int vcnt = 0;
  int beat = 0;
  int burst_left = 0;
  int last_cyc = 0;
  bit last_load = 1'b0;
  bit check_spacing = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input int val, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d with no expected event queued", name, val);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check(name, val, e.val);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < CMD_N; i++) begin
      sb.push_back('{0, rom[i]});
      if (rom[i] == 0)
        for (int p = 0; p < IMAGE_N; p++) sb.push_back('{1, p + 16});
    end
    sb.push_back('{2, CMD_N});
  endtask

  // Monitor: compares every DUT event against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        burst_left = 0;
      end else begin
        if (burst_left > 0) begin
          check("burst_gap", int'(datain != 8'd0), 1);
          burst_left--;
        end
        if (datain != 8'd0) begin
          sb_pop(1, int'(datain), "pixel");
          beat++;
        end
        if (cmd_valid) begin
          vcnt++;
          check("busy_at_issue", int'(busy_edge), 0);
          sb_pop(0, int'(cmd), "cmd");
          if (check_spacing && cmd_count != 5'd1)
            check("cmd_spacing", cyc - last_cyc, last_load ? 4 + IMAGE_N : 4);
          last_cyc  = cyc;
          last_load = (cmd == 3'd0);
          if (cmd == 3'd0) begin
            burst_left = IMAGE_N;
            beat = 0;
          end
        end
        if (done) begin
          done_cnt++;
          check("done_busy", int'(busy_edge), 0);
          sb_pop(2, int'(cmd_count), "done_count");
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, int'(done_cnt != d0), 1);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_queue_left"}, sb.size(), 0);
    check({name, "_count_hold"}, int'(cmd_count), CMD_N);
    check({name, "_running_low"}, int'(running), 0);
  endtask

  task automatic wait_beat(input int target, input string name);
    int n = 0;
    while (beat != target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_beat_reached"}, beat, target);
  endtask

  int d_before;
  int v_before;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          int'(|{cmd, cmd_valid, datain, running, done, cmd_count, img_rom_addr, cmd_rom_addr}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_running", int'(running), 0);

    // Run 1: busy tied low, exact spacing and contiguous bursts.
    check_spacing = 1'b1;
    push_run();
    pulse_start();
    check("running_after_start", int'(running), 1);
    wait_done(3000, "run_free");

    // Run 2: busy model, done exactly once.
    check_spacing = 1'b0;
    busy_mode = 1;
    d_before = done_cnt;
    push_run();
    pulse_start();
    wait_done(5000, "run_busy");
    repeat (30) @(negedge clk);
    #1;
    check("done_once", done_cnt - d_before, 1);
    busy_mode = 0;

    // Run 3: busy held high 500 cycles while the first command waits.
    check_spacing = 1'b1;
    busy_force = 1'b1;
    push_run();
    v_before = vcnt;
    pulse_start();
    repeat (500) @(negedge clk);
    #1;
    check("no_issue_while_busy", vcnt - v_before, 0);
    busy_force = 1'b0;
    @(negedge clk); #1;
    check("issue_after_busy", int'(cmd_valid), 1);
    wait_done(3000, "run_hold");

    // Run 4: start pulsed mid-burst is ignored.
    push_run();
    pulse_start();
    wait_beat(50, "midstart");
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("midstart_running", int'(running), 1);
    wait_done(3000, "run_midstart");

    // Run 5: asynchronous reset in the middle of a burst, then a clean restart.
    push_run();
    pulse_start();
    wait_beat(30, "reset_mid");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          int'(|{cmd, cmd_valid, datain, running, done, cmd_count, img_rom_addr, cmd_rom_addr}), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    push_run();
    pulse_start();
    wait_done(3000, "run_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
